// File: rtl/fb_ctrl_pkg.sv
// fb_ctrl_pkg: state and write-port select encodings shared by the framebuffer draw controller
package fb_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, ARM, CLEAR, DRAW, DRAIN, DONE} state_e;
    typedef enum logic [1:0] {SEL_NONE, SEL_CLEAR, SEL_RENDER} sel_e;
endpackage

// File: rtl/fb_clear_seq.sv
// fb_clear_seq: linear address sweep 0..N-1 with registered write outputs
module fb_clear_seq #(
    parameter int N  = 57600,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    output logic          we,
    output logic [AW-1:0] addr,
    output logic          last
);
    assign last = we && addr == AW'(N - 1);

    always_ff @(posedge clk) begin
        if (!rst_n || stop) begin
            we   <= 1'b0;
            addr <= '0;
        end else if (start) begin
            we   <= 1'b1;
            addr <= '0;
        end else if (we) begin
            we   <= !last;
            addr <= last ? '0 : addr + 1'b1;
        end
    end
endmodule

// File: rtl/fb_draw_ctrl.sv
// fb_draw_ctrl: per-frame clear/render/drain sequencer owning the framebuffer write port
module fb_draw_ctrl
    import fb_ctrl_pkg::*;
#(
    parameter int CIDXW     = 4,
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 180,
    parameter int FB_ADDRW  = $clog2(FB_WIDTH * FB_HEIGHT),
    parameter int LAT_ADDR  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame,
    input  logic                cmd_start,
    input  logic                cmd_clear,
    input  logic                cmd_auto,
    input  logic                cmd_abort,
    input  logic [CIDXW-1:0]    bg_cidx,
    output logic                render_start,
    input  logic                render_done,
    input  logic                rw_we,
    input  logic [FB_ADDRW-1:0] rw_addr,
    input  logic [CIDXW-1:0]    rw_cidx,
    output logic                fb_we,
    output logic [FB_ADDRW-1:0] fb_addr,
    output logic [CIDXW-1:0]    fb_cidx,
    output logic                busy,
    output logic                done
);
    localparam int DW = LAT_ADDR > 1 ? $clog2(LAT_ADDR) : 1;

    state_e              state, next;
    sel_e                sel;
    logic                clr_q, was_draw, cs_start, cs_we, cs_last;
    logic [CIDXW-1:0]    bg_q;
    logic [DW-1:0]       dcnt;
    logic [FB_ADDRW-1:0] cs_addr;

    assign cs_start = state == ARM && frame && clr_q && !cmd_abort;

    fb_clear_seq #(.N(FB_WIDTH * FB_HEIGHT), .AW(FB_ADDRW)) u_clear (
        .clk  (clk),
        .rst_n(rst_n),
        .start(cs_start),
        .stop (cmd_abort),
        .we   (cs_we),
        .addr (cs_addr),
        .last (cs_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            clr_q    <= 1'b0;
            bg_q     <= '0;
            was_draw <= 1'b0;
            dcnt     <= '0;
        end else begin
            state    <= next;
            was_draw <= state == DRAW;
            dcnt     <= state == DRAIN ? dcnt + 1'b1 : '0;
            if (state == IDLE && cmd_start && !cmd_abort) begin
                clr_q <= cmd_clear;
                bg_q  <= bg_cidx;
            end
        end
    end

    // render_done in the first DRAW cycle is stale, so only honour it once was_draw is set
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = cmd_start ? ARM : IDLE;
            ARM:     next = frame ? (clr_q ? CLEAR : DRAW) : ARM;
            CLEAR:   next = cs_last ? DRAW : CLEAR;
            DRAW:    next = render_done && was_draw ? DRAIN : DRAW;
            DRAIN:   next = dcnt == DW'(LAT_ADDR - 1) ? DONE : DRAIN;
            DONE:    next = cmd_auto ? ARM : IDLE;
            default: next = IDLE;
        endcase
        if (cmd_abort) next = IDLE;
    end

    assign sel = state == CLEAR ? SEL_CLEAR
               : (state == DRAW || state == DRAIN) ? SEL_RENDER : SEL_NONE;

    assign fb_we   = sel == SEL_CLEAR ? cs_we   : sel == SEL_RENDER ? rw_we   : 1'b0;
    assign fb_addr = sel == SEL_CLEAR ? cs_addr : sel == SEL_RENDER ? rw_addr : '0;
    assign fb_cidx = sel == SEL_CLEAR ? bg_q    : sel == SEL_RENDER ? rw_cidx : '0;

    assign render_start = state == DRAW && !was_draw;
    assign busy         = state != IDLE;
    assign done         = state == DONE;
endmodule

// File: tb/tb_fb_draw_ctrl.sv
// tb_fb_draw_ctrl: randomized directed sequences checked against timeline arithmetic
module tb_fb_draw_ctrl;
    localparam int CW = 4, W = 8, H = 4, N = W * H, AW = 5, LAT = 3;

    logic clk = 1'b0, rst_n = 1'b0;
    logic frame, cmd_start, cmd_clear, cmd_auto, cmd_abort, render_done, rw_we;
    logic [CW-1:0] bg_cidx, rw_cidx;
    logic [AW-1:0] rw_addr;
    logic render_start, fb_we, busy, done;
    logic [AW-1:0] fb_addr;
    logic [CW-1:0] fb_cidx;
    int total = 0, fails = 0, cyc = 0, ndone = 0;

    fb_draw_ctrl #(.CIDXW(CW), .FB_WIDTH(W), .FB_HEIGHT(H), .FB_ADDRW(AW), .LAT_ADDR(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .frame(frame), .cmd_start(cmd_start), .cmd_clear(cmd_clear),
        .cmd_auto(cmd_auto), .cmd_abort(cmd_abort), .bg_cidx(bg_cidx), .render_start(render_start),
        .render_done(render_done), .rw_we(rw_we), .rw_addr(rw_addr), .rw_cidx(rw_cidx),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_cidx(fb_cidx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (done === 1'b1) ndone++;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic quiet();
        frame = 0; cmd_start = 0; cmd_clear = 0; cmd_auto = 0; cmd_abort = 0;
        bg_cidx = '0; render_done = 0; rw_we = 0; rw_addr = '0; rw_cidx = '0;
    endtask

    task automatic noise();
        rw_we = 1'($urandom); rw_addr = AW'($urandom); rw_cidx = CW'($urandom);
        cmd_start = 1'($urandom); cmd_clear = 1'($urandom); bg_cidx = CW'($urandom);
        frame = 1'($urandom); render_done = 1'($urandom); cmd_auto = 0; cmd_abort = 0;
    endtask

    // fwd: render port forwarded this cycle, so address/colour are only defined when writing
    task automatic expect_out(input bit fwd, input logic we, input logic [AW-1:0] a,
                              input logic [CW-1:0] c, input logic rs, input logic bsy, input logic dn);
        #1;
        chk("fb_we", 32'(fb_we), 32'(we));
        if (we || !fwd) begin
            chk("fb_addr", 32'(fb_addr), 32'(a));
            chk("fb_cidx", 32'(fb_cidx), 32'(c));
        end
        chk("render_start", 32'(render_start), 32'(rs));
        chk("busy", 32'(busy), 32'(bsy));
        chk("done", 32'(done), 32'(dn));
    endtask

    task automatic seq(input bit clr, input logic [CW-1:0] bg, input int fdel, input int rlen,
                       input bit auto_on, input bit from_idle);
        int fc, dn0;
        dn0 = ndone;
        if (from_idle) begin
            quiet(); cmd_start = 1; cmd_clear = clr; bg_cidx = bg; rw_we = 1;
            expect_out(0, 0, 0, 0, 0, 0, 0);
            step();
        end
        for (int i = 0; i < fdel; i++) begin
            noise(); frame = 0;
            expect_out(0, 0, 0, 0, 0, 1, 0);
            step();
        end
        noise(); frame = 1; fc = cyc;
        expect_out(0, 0, 0, 0, 0, 1, 0);
        step();
        if (clr) for (int i = 0; i < N; i++) begin
            noise();
            expect_out(0, 1, AW'(i), bg, 0, 1, 0);
            if (i == 0) chk("clr_first_cyc", cyc, fc + 1);
            if (i == N - 1) chk("clr_last_cyc", cyc, fc + N);
            step();
        end
        for (int i = 0; i < rlen; i++) begin
            noise();
            render_done = (i == rlen - 1) || (i == 0 && 1'($urandom));
            expect_out(1, rw_we, rw_addr, rw_cidx, i == 0, 1, 0);
            if (i == 0) chk("rs_cyc", cyc, fc + (clr ? N : 0) + 1);
            step();
        end
        for (int i = 0; i < LAT; i++) begin
            noise();
            expect_out(1, rw_we, rw_addr, rw_cidx, 0, 1, 0);
            step();
        end
        noise(); cmd_auto = auto_on;
        expect_out(0, 0, 0, 0, 0, 1, 1);
        chk("done_cyc", cyc, fc + (clr ? N : 0) + rlen + LAT + 1);
        step();
        chk("done_count", ndone, dn0 + 1);
        if (!auto_on) begin
            quiet(); rw_we = 1;
            expect_out(0, 0, 0, 0, 0, 0, 0);
            step();
        end
    endtask

    initial begin
        int dn0;
        quiet();
        rst_n = 0;
        step();
        expect_out(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1;
        step();

        seq(1, 4'hA, 8, 8, 0, 1);
        seq(0, 4'h3, 4, 4, 0, 1);
        seq(1, 4'h5, 2, 3, 1, 1);
        seq(1, 4'h5, 1, 2, 0, 0);
        for (int k = 0; k < 4; k++)
            seq(1'($urandom), CW'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(2, 6)), 0, 1);

        // abort in the middle of a clear
        dn0 = ndone;
        quiet(); cmd_start = 1; cmd_clear = 1; bg_cidx = 4'h6;
        expect_out(0, 0, 0, 0, 0, 0, 0);
        step();
        quiet(); frame = 1;
        expect_out(0, 0, 0, 0, 0, 1, 0);
        step();
        for (int i = 0; i <= 12; i++) begin
            noise();
            cmd_abort = (i == 12);
            expect_out(0, 1, AW'(i), 4'h6, 0, 1, 0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            quiet(); rw_we = 1; frame = 1;
            expect_out(0, 0, 0, 0, 0, 0, 0);
            step();
        end
        chk("abort_no_done", ndone, dn0);

        // start and abort together in IDLE
        quiet(); cmd_start = 1; cmd_clear = 0; cmd_abort = 1;
        expect_out(0, 0, 0, 0, 0, 0, 0);
        step();
        quiet(); frame = 1;
        expect_out(0, 0, 0, 0, 0, 0, 0);
        step();
        quiet();
        expect_out(0, 0, 0, 0, 0, 0, 0);
        step();

        // reset in the middle of DRAW
        dn0 = ndone;
        quiet(); cmd_start = 1;
        expect_out(0, 0, 0, 0, 0, 0, 0);
        step();
        quiet(); frame = 1;
        expect_out(0, 0, 0, 0, 0, 1, 0);
        step();
        quiet(); rw_we = 1; rw_addr = 5'd7; rw_cidx = 4'h3;
        expect_out(1, 1, 5'd7, 4'h3, 1, 1, 0);
        step();
        quiet(); rw_we = 1; rw_addr = 5'd9; rw_cidx = 4'hC; rst_n = 0;
        expect_out(1, 1, 5'd9, 4'hC, 0, 1, 0);
        step();
        rst_n = 1; quiet(); rw_we = 1; rw_addr = 5'd9;
        expect_out(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("reset_no_done", ndone, dn0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fb_draw_ctrl.md
Name: fb_draw_ctrl

Overview:
Sequences framebuffer drawing for one frame and owns the framebuffer write port. On request it waits for frame start and optionally clears the framebuffer to a background colour index. It then starts the render engine and forwards its pixel writes from the address pipeline. Finally it drains the address-pipeline latency and reports completion. It sits between the render module, the bitmap address pipeline and the framebuffer BRAM write port, in the system clock domain.

Parameters:
CIDXW, 4, colour index width (bits)
FB_WIDTH, 320, framebuffer width (pixels)
FB_HEIGHT, 180, framebuffer height (pixels)
FB_ADDRW, $clog2(FB_WIDTH*FB_HEIGHT), framebuffer address width
LAT_ADDR, 3, render address-pipeline latency to drain after render done (cycles, >=1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
frame  in  1  frame-start pulse (system domain)
cmd_start  in  1  request one draw sequence (pulse)
cmd_clear  in  1  sampled with cmd_start: clear before render
cmd_auto  in  1  level: re-arm automatically after done
cmd_abort  in  1  abandon sequence (pulse)
bg_cidx  in  CIDXW  clear colour, sampled with cmd_start
render_start  out  1  one-cycle start pulse to render engine
render_done  in  1  render engine finished (pulse)
rw_we  in  1  render write enable (after address pipeline, clip applied)
rw_addr  in  FB_ADDRW  render write address
rw_cidx  in  CIDXW  render write colour index
fb_we  out  1  framebuffer write enable
fb_addr  out  FB_ADDRW  framebuffer write address
fb_cidx  out  CIDXW  framebuffer write colour index
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at sequence completion

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE; render_start, done and busy all 0; clear counter 0; latched clear/colour 0.
- Reset and abort take effect mid-operation: the next cycle is IDLE with fb_we 0 and no done pulse.
- Clear writes are registered. Render writes pass combinationally from rw_* only in DRAW and DRAIN.
- In all other states fb_we is 0 and fb_addr/fb_cidx are 0.
- States:
  - IDLE: cmd_start latches cmd_clear and bg_cidx, then goes to ARM next cycle.
  - ARM: waits for frame. On frame, goes to CLEAR if clear is latched, else to DRAW.
  - CLEAR: counter runs 0..N-1 (N = FB_WIDTH*FB_HEIGHT), one write per cycle, fb_cidx = latched bg_cidx. The counter does not wrap. After the write at N-1, goes to DRAW.
  - DRAW: render_start is high only in the first DRAW cycle. render_done is honoured only from the second DRAW cycle onward. It moves to DRAIN.
  - DRAIN: lasts exactly LAT_ADDR cycles with writes still forwarded, then DONE.
  - DONE: one cycle with done=1. Next state is ARM if cmd_auto is high (latched clear/colour reused), else IDLE.
- Timing (frame seen at cycle f, clear enabled):
  - First clear write at f+1 (addr 0).
  - Last clear write at f+N.
  - render_start at f+N+1.
- Timing without clear: render_start at f+1.
- Ignored inputs and priority:
  - cmd_start is ignored outside IDLE.
  - frame is ignored outside ARM. A frame pulse during CLEAR/DRAW does not restart.
  - rw_we outside DRAW/DRAIN is dropped.
  - cmd_abort beats every other input in the same cycle.
  - cmd_start together with cmd_abort in IDLE: abort wins, stays IDLE.

Decomposition:
- Package fb_ctrl_pkg holds the state enum (IDLE, ARM, CLEAR, DRAW, DRAIN, DONE) and the write-port mux select encoding.
- Sub-module fb_clear_seq is the natural split: the linear address counter with start/last/registered write outputs, reusable by other demos.

Test Plan:
- FB 8x4 (N=32), cmd_start with cmd_clear=1, bg_cidx=4'hA, frame at cycle 10:
  - fb_we high cycles 11..42.
  - Addresses 0..31, cidx A.
  - render_start at 43.
  - render_done at 50 gives DRAIN 51..53 and done at 54.
- cmd_clear=0, frame at cycle 5:
  - No clear writes; render_start at 6.
  - rw_we/addr 7/cidx 3 in DRAW appears on fb_* the same cycle.
  - rw_we in IDLE gives fb_we 0.
- Extra frame pulse during CLEAR: no restart, address sequence continuous.
- Second cmd_start while busy: ignored, single done pulse.
- cmd_auto=1: after done, state ARM. The next frame repeats the clear with the same bg_cidx, done once per sequence.
- Abort and reset in CLEAR:
  - cmd_abort at clear address 12: next cycle fb_we 0, busy 0, no done.
  - rst_n low mid-DRAW: all outputs 0 next cycle.
